mtx_lock_arbiter: RTL and testbench

Parametrised packet-level matrix arbiter for router switch/VC allocation. It keeps an N×N least-recently-granted priority matrix and adds two features: an urgent priority class, and wormhole locking. Locking holds a grant on one requester from head flit to tail flit, gated by a downstream ready handshake. It sits between the input-port request logic and the crossbar select of each output port.

---
 rtl/mtx_lock_arbiter_if.sv | 32 +++
 rtl/mtx_lock_arbiter.sv | 115 +++++++++++
 tb/tb_mtx_lock_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mtx_lock_arbiter_if.sv
// ============================================================================
// Module   : mtx_lock_arbiter_if
// Brief    : Request/grant bundle between input-port request logic and the
//            per-output-port matrix lock arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mtx_lock_arbiter_if #(
  parameter int LEN   = 5,
  parameter int IDX_W = $clog2(LEN)
) ();
  logic [LEN-1:0]   request;
  logic [LEN-1:0]   req_urgent;
  logic [LEN-1:0]   req_tail;
  logic             ready;
  logic [LEN-1:0]   grant;
  logic [IDX_W-1:0] grant_idx;
  logic             locked;

  modport master (
    output request, req_urgent, req_tail, ready,
    input  grant, grant_idx, locked
  );

  modport slave (
    input  request, req_urgent, req_tail, ready,
    output grant, grant_idx, locked
  );
endinterface

`default_nettype wire

// File: rtl/mtx_lock_arbiter.sv
// ============================================================================
// Module   : mtx_lock_arbiter
// Brief    : Least-recently-granted matrix arbiter with an urgent class and
//            head-to-tail wormhole locking gated by downstream ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtx_lock_arbiter #(
  parameter int LEN   = 5,
  parameter int IDX_W = $clog2(LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  mtx_lock_arbiter_if.slave  arb
);

  // Only the upper triangle w[i][j], i<j, is stored; w[j][i] is its inverse.
  localparam int c_NPAIR = LEN * (LEN - 1) / 2;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_lock_id;
  logic [IDX_W-1:0]     w_lock_id_nxt;
  logic [c_NPAIR-1:0]   r_pri;
  logic [c_NPAIR-1:0]   w_pri_nxt;

  logic [LEN-1:0]       w_beaten_by [LEN];
  logic [LEN-1:0]       w_urg;
  logic [LEN-1:0]       w_elig;
  logic [LEN-1:0]       w_arb;
  logic [LEN-1:0]       w_lock_oh;
  logic [LEN-1:0]       w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_xfer;
  logic                 w_tail;
  logic                 w_upd;

  assign w_urg  = arb.request & arb.req_urgent;
  assign w_elig = (|w_urg) ? w_urg : arb.request;

  // w_beaten_by[i] bit j is w[j][i]; w_pri_nxt moves the packet winner to the bottom.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_row
    for (genvar gj = 0; gj < LEN; gj++) begin : g_col
      if (gi < gj) begin : g_upper
        localparam int c_K = gi * LEN - (gi * (gi + 1)) / 2 + (gj - gi - 1);
        assign w_beaten_by[gj][gi] = r_pri[c_K];
        assign w_beaten_by[gi][gj] = ~r_pri[c_K];
        assign w_pri_nxt[c_K] = !w_upd        ? r_pri[c_K] :
                                w_grant[gj]   ? 1'b1       :
                                w_grant[gi]   ? 1'b0       : r_pri[c_K];
      end else if (gi == gj) begin : g_diag
        assign w_beaten_by[gi][gi] = 1'b0;
      end
    end

    assign w_arb[gi]     = w_elig[gi] & ~(|(w_elig & w_beaten_by[gi]));
    assign w_lock_oh[gi] = (r_lock_id == IDX_W'(gi));
  end

  assign w_grant = (r_state == S_LOCKED) ? (arb.request & w_lock_oh) : w_arb;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < LEN; i++) begin
      if (w_grant[i]) w_idx = w_idx | IDX_W'(i);
    end
  end

  // Grant is one-hot, so the tail bit of the winner is a simple masked OR.
  assign w_xfer = (|w_grant) & arb.ready;
  assign w_tail = |(w_grant & arb.req_tail);
  assign w_upd  = w_xfer & w_tail;

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && !w_tail) begin
          w_state_nxt   = S_LOCKED;
          w_lock_id_nxt = w_idx;
        end
      end
      S_LOCKED: begin
        if (w_xfer && w_tail) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_lock_id <= '0;
      r_pri     <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_pri     <= w_pri_nxt;
    end
  end

  assign arb.grant     = w_grant;
  assign arb.grant_idx = w_idx;
  assign arb.locked    = (r_state == S_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_mtx_lock_arbiter.sv
// ============================================================================
// Module   : tb_mtx_lock_arbiter
// Brief    : Directed bench for mtx_lock_arbiter with LEN=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtx_lock_arbiter;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  mtx_lock_arbiter_if #(.LEN(4), .IDX_W(2)) bus ();

  mtx_lock_arbiter #(.LEN(4), .IDX_W(2)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .arb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] urg,
                       input logic [3:0] tail, input logic rdy);
    bus.request    = req;
    bus.req_urgent = urg;
    bus.req_tail   = tail;
    bus.ready      = rdy;
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_idx", 32'(bus.grant_idx), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Single-flit packets rotate between requesters 1 and 3
    drive(4'b1010, 4'b0000, 4'b1111, 1'b1);
    chk("rr0_grant", 32'(bus.grant), 32'h2);
    chk("rr0_idx", 32'(bus.grant_idx), 32'h1);
    chk("rr0_locked", 32'(bus.locked), 32'h0);
    tick(); #2;
    chk("rr1_grant", 32'(bus.grant), 32'h8);
    chk("rr1_idx", 32'(bus.grant_idx), 32'h3);
    chk("rr1_locked", 32'(bus.locked), 32'h0);
    tick(); #2;
    chk("rr2_grant", 32'(bus.grant), 32'h2);
    chk("rr2_idx", 32'(bus.grant_idx), 32'h1);
    tick(); #2;
    chk("rr3_grant", 32'(bus.grant), 32'h8);
    chk("rr3_idx", 32'(bus.grant_idx), 32'h3);
    chk("rr3_locked", 32'(bus.locked), 32'h0);
    tick();

    // Multi-flit packet from requester 0 locks the output
    drive(4'b0011, 4'b0000, 4'b0000, 1'b1);
    chk("lk0_grant", 32'(bus.grant), 32'h1);
    chk("lk0_locked", 32'(bus.locked), 32'h0);
    tick(); #2;
    chk("lk1_grant", 32'(bus.grant), 32'h1);
    chk("lk1_locked", 32'(bus.locked), 32'h1);
    tick(); #2;
    chk("lk2_grant", 32'(bus.grant), 32'h1);
    chk("lk2_locked", 32'(bus.locked), 32'h1);
    tick();
    drive(4'b0011, 4'b0000, 4'b0001, 1'b1);
    chk("lk3_grant", 32'(bus.grant), 32'h1);
    chk("lk3_locked", 32'(bus.locked), 32'h1);
    tick(); #2;
    chk("lk4_grant", 32'(bus.grant), 32'h2);
    chk("lk4_idx", 32'(bus.grant_idx), 32'h1);
    chk("lk4_locked", 32'(bus.locked), 32'h0);

    do_reset();

    // Urgent class beats the matrix; matrix decides inside the urgent set
    drive(4'b0111, 4'b0100, 4'b0000, 1'b0);
    chk("urg_a_grant", 32'(bus.grant), 32'h4);
    chk("urg_a_idx", 32'(bus.grant_idx), 32'h2);
    drive(4'b0111, 4'b0110, 4'b0000, 1'b0);
    chk("urg_b_grant", 32'(bus.grant), 32'h2);
    chk("urg_b_idx", 32'(bus.grant_idx), 32'h1);
    tick();

    // ready low freezes all state
    drive(4'b0110, 4'b0000, 4'b0110, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_grant", 32'(bus.grant), 32'h2);
      chk("stall_locked", 32'(bus.locked), 32'h0);
      tick(); #2;
    end
    drive(4'b0110, 4'b0000, 4'b0110, 1'b1);
    chk("rel_grant", 32'(bus.grant), 32'h2);
    tick(); #2;
    chk("next_grant", 32'(bus.grant), 32'h4);

    // Head flit from requester 2 locks it; no preemption by urgent requester 0
    drive(4'b0110, 4'b0000, 4'b0000, 1'b1);
    tick(); #2;
    chk("own_grant", 32'(bus.grant), 32'h4);
    chk("own_locked", 32'(bus.locked), 32'h1);
    tick();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    chk("gap0_grant", 32'(bus.grant), 32'h0);
    chk("gap0_idx", 32'(bus.grant_idx), 32'h0);
    chk("gap0_locked", 32'(bus.locked), 32'h1);
    tick(); #2;
    chk("gap1_grant", 32'(bus.grant), 32'h0);
    chk("gap1_locked", 32'(bus.locked), 32'h1);
    tick();
    drive(4'b0101, 4'b0000, 4'b0000, 1'b1);
    chk("resume_grant", 32'(bus.grant), 32'h4);
    chk("resume_idx", 32'(bus.grant_idx), 32'h2);
    chk("resume_locked", 32'(bus.locked), 32'h1);

    // Asynchronous reset mid-packet drops the lock at once
    rstn = 1'b0;
    #1;
    chk("arst_locked", 32'(bus.locked), 32'h0);
    chk("arst_grant", 32'(bus.grant), 32'h1);
    tick();
    rstn = 1'b1;
    drive(4'b0101, 4'b0000, 4'b0000, 1'b0);
    chk("post_rst_grant", 32'(bus.grant), 32'h1);
    chk("post_rst_idx", 32'(bus.grant_idx), 32'h0);
    chk("post_rst_locked", 32'(bus.locked), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
